// File: rtl/rtx_pkg.sv
// Shared definitions for the serial result transmitter: FSM states,
// default word width and a frame-length helper.
package rtx_pkg;

  localparam int DEFAULT_DATA_W = 40;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Total clk cycles from first start-bit cycle to last stop-bit cycle.
  function automatic int frame_len(input int data_w, input int parity_en,
                                   input int clks_per_bit);
    return (data_w + 2 + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Divides clk down to one tick per serial bit; held clear while disabled so
// every bit period starts from zero.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With one clk per bit LAST is zero, so cnt never leaves 0 and tick == en.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/result_serial_tx.sv
// Serialises one result word per handshake: start bit, data LSB first,
// optional even parity, stop bit. Line idles high.
module result_serial_tx
  import rtx_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              accept;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tx       = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        tx = 1'b0;
        if (tick) state_nx = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (tick && (idx == LAST_IDX)) begin
          state_nx = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx = par;
        if (tick) state_nx = STOP;
      end
      STOP: begin
        tx   = 1'b1;
        done = tick && !rst;
        if (tick) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // The word and its parity are frozen at accept, so later in_data changes
  // cannot disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      par   <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      shreg <= in_data;
      par   <= ^in_data;
      idx   <= '0;
    end else if ((state == DATA) && tick) begin
      shreg <= shreg >> 1;
      idx   <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_result_serial_tx.sv
// Randomised self-checking bench: a frame-level model predicts every tx/busy/done
// cycle for a default instance and a 1-clk-per-bit, no-parity instance.
module tb_result_serial_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] data0 = '0, data1 = '0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        ready0, ready1, tx0, tx1, busy0, busy1, done0, done1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  result_serial_tx dut0 (
    .clk(clk), .rst(rst), .in_data(data0), .in_valid(valid0),
    .in_ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
  );

  result_serial_tx #(.DATA_W(40), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .in_data(data1), .in_valid(valid1),
    .in_ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[39:0];
  endfunction

  function automatic logic getTx(input int w);   return (w == 0) ? tx0 : tx1; endfunction
  function automatic logic getBusy(input int w); return (w == 0) ? busy0 : busy1; endfunction
  function automatic logic getDone(input int w); return (w == 0) ? done0 : done1; endfunction
  function automatic logic getReady(input int w); return (w == 0) ? ready0 : ready1; endfunction

  task automatic applyStimulus(input int w, input logic v, input logic [39:0] d);
    if (w == 0) begin valid0 = v; data0 = d; end
    else        begin valid1 = v; data1 = d; end
  endtask

  task automatic waitReady(input int w);
    int n = 0;
    while (!getReady(w) && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) checkOutput("ready_timeout", 64'd0, 64'd1);
  endtask

  // Entered on the first cycle after accept; leaves on the first idle cycle.
  task automatic frameCheck(input int w, input logic [39:0] word);
    int cpb, pen, len, b;
    logic bits[$];
    logic [39:0] rec;
    cpb = (w == 0) ? 4 : 1;
    pen = (w == 0) ? 1 : 0;
    len = (40 + 2 + pen) * cpb;
    rec = '0;
    bits.push_back(1'b0);
    for (int i = 0; i < 40; i++) bits.push_back(word[i]);
    if (pen != 0) bits.push_back(logic'($countones(word) % 2));
    bits.push_back(1'b1);
    for (int k = 1; k <= len; k++) begin
      b = (k - 1) / cpb;
      checkOutput("tx", 64'(getTx(w)), 64'(bits[b]));
      checkOutput("busy", 64'(getBusy(w)), 64'd1);
      checkOutput("done", 64'(getDone(w)), 64'(k == len));
      checkOutput("ready_in_frame", 64'(getReady(w)), 64'd0);
      if (b >= 1 && b <= 40 && ((k - 1) % cpb) == cpb / 2) rec[b-1] = getTx(w);
      step();
    end
    checkOutput("recovered_word", 64'(rec), 64'(word));
    checkOutput("tx_after", 64'(getTx(w)), 64'd1);
    checkOutput("busy_after", 64'(getBusy(w)), 64'd0);
    checkOutput("ready_after", 64'(getReady(w)), 64'd1);
  endtask

  task automatic sendWord(input int w, input logic [39:0] word, input bit hold,
                          input logic [39:0] holdWord);
    waitReady(w);
    applyStimulus(w, 1'b1, word);
    step();
    if (hold) applyStimulus(w, 1'b1, holdWord);
    else      applyStimulus(w, 1'b0, rnd40());
    frameCheck(w, word);
    if (hold) begin
      step();
      applyStimulus(w, 1'b0, rnd40());
      frameCheck(w, holdWord);
    end
  endtask

  initial begin
    repeat (3) step();
    checkOutput("rst_ready", 64'(ready0), 64'd0);
    checkOutput("rst_tx", 64'(tx0), 64'd1);
    checkOutput("rst_busy", 64'(busy0), 64'd0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("idle_tx0", 64'(tx0), 64'd1);
      checkOutput("idle_busy0", 64'(busy0), 64'd0);
      checkOutput("idle_ready0", 64'(ready0), 64'd1);
      checkOutput("idle_done0", 64'(done0), 64'd0);
      checkOutput("idle_tx1", 64'(tx1), 64'd1);
      checkOutput("idle_ready1", 64'(ready1), 64'd1);
      step();
    end

    sendWord(0, 40'h00_0000_0001, 1'b0, '0);
    sendWord(0, 40'hA5_A5A5_A5A5, 1'b0, '0);
    sendWord(0, rnd40(), 1'b1, 40'hFF_FFFF_FFFF);
    repeat (3) sendWord(0, rnd40(), 1'b0, '0);

    sendWord(1, 40'h80_0000_0000, 1'b0, '0);
    sendWord(1, rnd40(), 1'b1, rnd40());
    sendWord(1, rnd40(), 1'b0, '0);

    // Abort a frame on its 50th cycle.
    waitReady(0);
    applyStimulus(0, 1'b1, rnd40());
    step();
    applyStimulus(0, 1'b0, rnd40());
    for (int k = 1; k < 50; k++) begin
      checkOutput("pre_abort_done", 64'(done0), 64'd0);
      step();
    end
    rst = 1'b1;
    step();
    checkOutput("abort_tx", 64'(tx0), 64'd1);
    checkOutput("abort_busy", 64'(busy0), 64'd0);
    checkOutput("abort_done", 64'(done0), 64'd0);
    checkOutput("abort_ready_in_rst", 64'(ready0), 64'd0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 200; i++) begin
      checkOutput("post_abort_done", 64'(done0), 64'd0);
      checkOutput("post_abort_tx", 64'(tx0), 64'd1);
      step();
    end
    sendWord(0, rnd40(), 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
